// File: rtl/arc4_sched.sv
// arc4_sched: sequences the three RC4 engines (init, ksa, prga) and owns the
// single shared S-memory port on their behalf.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   en      / rdy              start request / scheduler idle and ready
//   err                        sticky abort flag (a stage overran TIMEOUT)
//   stage                      current owner: 0 none, 1 init, 2 ksa, 3 prga
//   en_i/en_k/en_p             one-cycle start pulses to the engines
//   rdy_i/rdy_k/rdy_p          engine ready inputs
//   addr_*/wrdata_*/wren_*     per-engine S-memory requests
//   s_addr/s_wrdata/s_wren     shared S-memory port, driven by the owner only
module arc4_sched #(
  parameter logic [19:0] TIMEOUT = 20'd600000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       err,
  output logic [1:0] stage,
  output logic       en_i,
  output logic       en_k,
  output logic       en_p,
  input  logic       rdy_i,
  input  logic       rdy_k,
  input  logic       rdy_p,
  input  logic [7:0] addr_i,
  input  logic [7:0] addr_k,
  input  logic [7:0] addr_p,
  input  logic [7:0] wrdata_i,
  input  logic [7:0] wrdata_k,
  input  logic [7:0] wrdata_p,
  input  logic       wren_i,
  input  logic       wren_k,
  input  logic       wren_p,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  typedef enum logic [3:0] {
    IDLE, ST_I, WT_I, ST_K, WT_K, ST_P, WT_P, DONE, ERR
  } state_e;

  localparam logic [19:0] LAST = TIMEOUT - 20'd1;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        expired;
  logic [19:0] cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ">=" rather than "==": a start pulse issued at the last count still
  // increments, so the following wait state must see the budget as spent.
  assign expired = (cnt_q >= LAST);
  assign cnt_inc = cnt_q + 20'd1;

  // The abort flag is exactly "sitting in ERR": an accepted en leaves ERR,
  // and reset forces IDLE, so no separate flag register is needed.
  assign err = (state_q == ERR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy     = 1'b0;
    stage   = 2'd0;
    en_i    = 1'b0;
    en_k    = 1'b0;
    en_p    = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        rdy = 1'b1;
        if (en) begin
          state_d = ST_I;
          cnt_d   = '0;
        end
      end
      // Start states: pulse the engine only once it reports ready. A launch
      // counts as progress, so it is not overridden by the timeout.
      ST_I: begin
        stage = 2'd1;
        if (rdy_i) begin
          en_i    = 1'b1;
          state_d = WT_I;
          cnt_d   = cnt_inc;
        end else if (expired) begin
          state_d = ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_K: begin
        stage = 2'd2;
        if (rdy_k) begin
          en_k    = 1'b1;
          state_d = WT_K;
          cnt_d   = cnt_inc;
        end else if (expired) begin
          state_d = ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_P: begin
        stage = 2'd3;
        if (rdy_p) begin
          en_p    = 1'b1;
          state_d = WT_P;
          cnt_d   = cnt_inc;
        end else if (expired) begin
          state_d = ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      // Wait states: completion is tested before expiry so that a finish on
      // the very last allowed cycle still counts as success.
      WT_I: begin
        stage = 2'd1;
        if (rdy_i) begin
          state_d = ST_K;
          cnt_d   = '0;
        end else if (expired) begin
          state_d = ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WT_K: begin
        stage = 2'd2;
        if (rdy_k) begin
          state_d = ST_P;
          cnt_d   = '0;
        end else if (expired) begin
          state_d = ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WT_P: begin
        stage = 2'd3;
        if (rdy_p) begin
          state_d = DONE;
          cnt_d   = '0;
        end else if (expired) begin
          state_d = ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Only the owning engine reaches the memory; with no owner the port is
  // parked at zero so a stray wren can never corrupt S.
  always_comb begin
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    case (stage)
      2'd1: begin
        s_addr   = addr_i;
        s_wrdata = wrdata_i;
        s_wren   = wren_i;
      end
      2'd2: begin
        s_addr   = addr_k;
        s_wrdata = wrdata_k;
        s_wren   = wren_k;
      end
      2'd3: begin
        s_addr   = addr_p;
        s_wrdata = wrdata_p;
        s_wren   = wren_p;
      end
      default: begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arc4_sched.sv
// Testbench for arc4_sched: engine models, a stage-level reference model
// and a per-cycle compare process, plus directed scenarios with literal
// expectations and a randomized soak.
module tb_arc4_sched;

  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy, err;
  logic [1:0] stage;
  logic       en_i, en_k, en_p;
  logic       rdy_i = 1'b1, rdy_k = 1'b1, rdy_p = 1'b1;
  logic [7:0] addr_i = '0, addr_k = '0, addr_p = '0;
  logic [7:0] wrdata_i = '0, wrdata_k = '0, wrdata_p = '0;
  logic       wren_i = 1'b0, wren_k = 1'b0, wren_p = 1'b0;
  logic [7:0] s_addr, s_wrdata;
  logic       s_wren;

  always #5 clk = ~clk;

  arc4_sched #(.TIMEOUT(20'd1000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .err(err), .stage(stage),
    .en_i(en_i), .en_k(en_k), .en_p(en_p),
    .rdy_i(rdy_i), .rdy_k(rdy_k), .rdy_p(rdy_p),
    .addr_i(addr_i), .addr_k(addr_k), .addr_p(addr_p),
    .wrdata_i(wrdata_i), .wrdata_k(wrdata_k), .wrdata_p(wrdata_p),
    .wren_i(wren_i), .wren_k(wren_k), .wren_p(wren_p),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Engine models: rdy drops after the edge that sees en, stays low for
  // lat cycles; hold forces rdy low on top of that.
  int lat_i = 1, lat_k = 1, lat_p = 1;
  int ci = 0, ck = 0, cp = 0;
  bit hold_i = 0, hold_k = 0, hold_p = 0;
  bit clr_eng = 0;
  always @(posedge clk) begin
    if (!rst_n || clr_eng) begin
      ci = 0; ck = 0; cp = 0;
    end else begin
      if (en_i) ci = lat_i; else if (ci > 0) ci--;
      if (en_k) ck = lat_k; else if (ck > 0) ck--;
      if (en_p) cp = lat_p; else if (cp > 0) cp--;
    end
    #1;
    rdy_i = (ci == 0) && !hold_i;
    rdy_k = (ck == 0) && !hold_k;
    rdy_p = (cp == 0) && !hold_p;
  end

  // Reference model: which stage owns the run, whether its engine has been
  // launched, and how many cycles the stage has consumed.
  int m_stage = 0;
  bit m_run = 0;
  int m_cnt = 0;
  bit m_err = 0;

  function automatic logic eng_rdy(input int s);
    case (s)
      1: return rdy_i;
      2: return rdy_k;
      3: return rdy_p;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage = 0; m_run = 0; m_cnt = 0; m_err = 0;
    end else if (m_stage == 0) begin
      if (en) begin
        m_stage = 1; m_run = 0; m_cnt = 0; m_err = 0;
      end
    end else if (eng_rdy(m_stage)) begin
      if (!m_run) begin
        m_run = 1;
        m_cnt++;
      end else begin
        m_stage = (m_stage == 3) ? 0 : m_stage + 1;
        m_run = 0;
        m_cnt = 0;
      end
    end else if (m_cnt >= TO - 1) begin
      m_stage = 0; m_run = 0; m_cnt = 0; m_err = 1;
    end else begin
      m_cnt++;
    end
  end

  // Per-cycle compare plus pulse bookkeeping for the directed checks.
  int n_ei = 0, n_ek = 0, n_ep = 0;
  int c_ei = 0, c_ek = 0, c_ep = 0;
  logic [7:0] e_addr, e_data;
  logic       e_wren;
  always @(negedge clk) begin
    case (m_stage)
      1: begin e_addr = addr_i; e_data = wrdata_i; e_wren = wren_i; end
      2: begin e_addr = addr_k; e_data = wrdata_k; e_wren = wren_k; end
      3: begin e_addr = addr_p; e_data = wrdata_p; e_wren = wren_p; end
      default: begin e_addr = 8'd0; e_data = 8'd0; e_wren = 1'b0; end
    endcase
    chk("rdy", rdy, m_stage == 0);
    chk("err", err, m_err);
    chk("stage", stage, m_stage);
    chk("en_i", en_i, m_stage == 1 && !m_run && rdy_i);
    chk("en_k", en_k, m_stage == 2 && !m_run && rdy_k);
    chk("en_p", en_p, m_stage == 3 && !m_run && rdy_p);
    chk("s_addr", s_addr, e_addr);
    chk("s_wrdata", s_wrdata, e_data);
    chk("s_wren", s_wren, e_wren);
    if (en_i) begin n_ei++; c_ei = cyc; end
    if (en_k) begin n_ek++; c_ek = cyc; end
    if (en_p) begin n_ep++; c_ep = cyc; end
  end

  bit bus_rand = 1;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus_rand) begin
      addr_i = 8'($urandom); addr_k = 8'($urandom); addr_p = 8'($urandom);
      wrdata_i = 8'($urandom); wrdata_k = 8'($urandom); wrdata_p = 8'($urandom);
      wren_i = 1'($urandom); wren_k = 1'($urandom); wren_p = 1'($urandom);
    end
    #1;
  endtask

  task automatic start_run();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  // what: 0 = back to ready, 2/3 = stage reached, 4 = err raised
  task automatic wait_for(input int what, input int lim, input string nm);
    bit hit;
    hit = 0;
    for (int n = 0; n < lim && !hit; n++) begin
      tick();
      case (what)
        0: hit = rdy;
        2: hit = (stage == 2'd2);
        3: hit = (stage == 2'd3);
        default: hit = err;
      endcase
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: no event within %0d cycles", nm, lim);
    end
  endtask

  int b_i, b_k, b_p, c0;

  initial begin
    // Reset state, held without any clock edge having taken effect
    #2;
    chk("reset_rdy", rdy, 1);
    chk("reset_stage", stage, 0);
    chk("reset_err", err, 0);
    chk("reset_s_wren", s_wren, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Normal run with 256/768/32 engine latencies
    lat_i = 256; lat_k = 768; lat_p = 32;
    b_i = n_ei; b_k = n_ek; b_p = n_ep;
    start_run();
    wait_for(0, 3000, "normal_done");
    chk("normal_en_i_count", n_ei - b_i, 1);
    chk("normal_en_k_count", n_ek - b_k, 1);
    chk("normal_en_p_count", n_ep - b_p, 1);
    chk("normal_i_to_k", c_ek - c_ei, 258);
    chk("normal_k_to_p", c_ep - c_ek, 770);
    chk("normal_p_to_done", cyc - c_ep, 34);
    chk("normal_err", err, 0);

    // Mux isolation during ksa, and en ignored while busy
    lat_i = 20; lat_k = 40; lat_p = 10;
    start_run();
    wait_for(2, 200, "iso_reach_ksa");
    tick();
    bus_rand = 0;
    addr_i = 8'hAA; wren_i = 1'b1; addr_k = 8'h33; wren_k = 1'b0;
    #1;
    chk("iso_s_addr", s_addr, 8'h33);
    chk("iso_s_wren", s_wren, 0);
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    chk("busy_en_stage", stage, 2);
    chk("busy_en_rdy", rdy, 0);
    wait_for(0, 200, "iso_done");
    chk("iso_done_err", err, 0);
    addr_p = 8'hC3; wren_p = 1'b1; wrdata_p = 8'h7E;
    #1;
    chk("idle_s_addr", s_addr, 0);
    chk("idle_s_wrdata", s_wrdata, 0);
    chk("idle_s_wren", s_wren, 0);
    bus_rand = 1;

    // Stall in ksa: ERR exactly TO cycles after entering ST_K
    lat_i = 3; lat_k = 5000; lat_p = 3;
    start_run();
    wait_for(2, 100, "stall_reach_ksa");
    c0 = cyc;
    wait_for(4, 2 * TO, "stall_err");
    chk("stall_err_delay", cyc - c0, TO);
    chk("stall_stage", stage, 0);
    chk("stall_rdy", rdy, 1);
    clr_eng = 1; tick(); clr_eng = 0;
    chk("stall_err_sticky", err, 1);
    lat_k = 3;
    start_run();
    chk("restart_clears_err", err, 0);
    wait_for(0, 200, "restart_done");

    // Completion on the last allowed prga cycle wins over the timeout
    lat_i = 2; lat_k = 2; lat_p = TO - 2;
    start_run();
    wait_for(3, 100, "edge_reach_prga");
    c0 = cyc;
    wait_for(0, 2 * TO, "edge_done");
    chk("edge_done_delay", cyc - c0, TO);
    chk("edge_err", err, 0);

    // Delayed start: init engine not ready for the first 5 cycles
    lat_i = 4; lat_k = 4; lat_p = 4;
    hold_i = 1;
    tick();
    b_i = n_ei;
    start_run();
    for (int n = 0; n < 5; n++) begin
      chk("delay_en_i_low", en_i, 0);
      chk("delay_stage", stage, 1);
      if (n < 4) tick();
    end
    hold_i = 0;
    tick();
    chk("delay_en_i_pulse", en_i, 1);
    tick();
    chk("delay_en_i_single", en_i, 0);
    wait_for(0, 200, "delay_done");
    chk("delay_en_i_count", n_ei - b_i, 1);

    // Asynchronous reset in WT_K, between clock edges
    lat_k = 200;
    start_run();
    wait_for(2, 100, "rst_reach_ksa");
    tick();
    bus_rand = 0;
    addr_k = 8'h5A; wren_k = 1'b1;
    #1;
    chk("pre_rst_s_wren", s_wren, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s_wren", s_wren, 0);
    chk("async_rst_s_addr", s_addr, 0);
    chk("async_rst_stage", stage, 0);
    chk("async_rst_rdy", rdy, 1);
    #2;
    rst_n = 1'b1;
    bus_rand = 1;
    b_k = n_ek;
    repeat (20) tick();
    chk("post_rst_no_en_k", n_ek - b_k, 0);
    chk("post_rst_stage", stage, 0);

    // Randomized soak against the model
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 9) == 0);
      hold_i = ($urandom_range(0, 7) == 0);
      hold_k = ($urandom_range(0, 7) == 0);
      hold_p = ($urandom_range(0, 7) == 0);
      lat_i = $urandom_range(1, 30);
      lat_k = $urandom_range(1, 30);
      lat_p = $urandom_range(1, 30);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    en = 1'b0; hold_i = 0; hold_k = 0; hold_p = 0; rst_n = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
